// File: rtl/lap_stopwatch_pkg.sv
// lap_stopwatch_pkg: shared state, BCD time type and the mm:ss:cc increment helper.
package lap_stopwatch_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;

    typedef struct packed {
        logic [3:0] mm_h;
        logic [3:0] mm_l;
        logic [3:0] ss_h;
        logic [3:0] ss_l;
        logic [3:0] cc_h;
        logic [3:0] cc_l;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = '0;

    typedef struct packed {
        bcd_time_t t;
        logic      wrap;
    } bcd_inc_t;

    function automatic bcd_inc_t bcd_time_inc(input bcd_time_t t, input int min_limit);
        bcd_inc_t   r;
        logic [3:0] lim_h;
        logic [3:0] lim_l;
        lim_h  = 4'(min_limit / 10);
        lim_l  = 4'(min_limit % 10);
        r.t    = t;
        r.wrap = 1'b0;
        if (t.cc_l != 4'd9)
            r.t.cc_l = t.cc_l + 4'd1;
        else begin
            r.t.cc_l = 4'd0;
            if (t.cc_h != 4'd9)
                r.t.cc_h = t.cc_h + 4'd1;
            else begin
                r.t.cc_h = 4'd0;
                if (t.ss_l != 4'd9)
                    r.t.ss_l = t.ss_l + 4'd1;
                else begin
                    r.t.ss_l = 4'd0;
                    if (t.ss_h != 4'd5)
                        r.t.ss_h = t.ss_h + 4'd1;
                    else begin
                        r.t.ss_h = 4'd0;
                        if (t.mm_h == lim_h && t.mm_l == lim_l) begin
                            r.t    = TIME_ZERO;
                            r.wrap = 1'b1;
                        end else if (t.mm_l != 4'd9)
                            r.t.mm_l = t.mm_l + 4'd1;
                        else begin
                            r.t.mm_l = 4'd0;
                            r.t.mm_h = t.mm_h + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lap_stopwatch_key_debounce.sv
// key_debounce: 2-FF synchroniser plus stable-count debouncer; one pulse per accepted press.
module key_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic key_reset,
    input  logic raw_n,
    output logic press_pulse
);

    localparam int CW = $clog2(DB_CYCLES) + 1;

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], raw_n};
            r_press <= 1'b0;
            if (r_sync[1] == r_level)
                r_cnt <= '0;
            else if (r_cnt == CW'(DB_CYCLES - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_press <= !r_sync[1];
            end else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign press_pulse = r_press;

endmodule

// File: rtl/lap_stopwatch.sv
// lap_stopwatch: BCD mm:ss:cc stopwatch with run FSM, N-entry lap memory and browsable lap view.
module lap_stopwatch
    import lap_stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 500000,
    parameter int DB_CYCLES = 1000000,
    parameter int LAP_DEPTH = 8,
    parameter int MIN_LIMIT = 59
) (
    input  logic       clk,
    input  logic       key_reset,
    input  logic       key_start_pause,
    input  logic       key_lap,
    input  logic       key_clear,
    output logic [3:0] data0,
    output logic [3:0] data1,
    output logic [3:0] data2,
    output logic [3:0] data3,
    output logic [3:0] data4,
    output logic [3:0] data5,
    output logic       led_run,
    output logic       led_view,
    output logic       led_full,
    output logic       led_wrap
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int IW = $clog2(LAP_DEPTH);
    localparam int CW = IW + 1;

    logic          w_start;
    logic          w_lap;
    logic          w_clear;
    state_t        r_state;
    state_t        w_state_next;
    logic [PW-1:0] r_presc;
    logic          w_tick;
    bcd_time_t     r_time;
    bcd_time_t     r_disp;
    bcd_inc_t      w_inc;
    bcd_time_t     r_lap [LAP_DEPTH];
    logic [CW-1:0] r_count;
    logic [IW-1:0] r_idx;
    logic          r_view;
    logic          r_wrap;
    logic          w_full;
    logic          w_lap_wr;
    logic          w_lap_view;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
        .clk(clk), .key_reset(key_reset), .raw_n(key_start_pause), .press_pulse(w_start)
    );
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
        .clk(clk), .key_reset(key_reset), .raw_n(key_lap), .press_pulse(w_lap)
    );
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
        .clk(clk), .key_reset(key_reset), .raw_n(key_clear), .press_pulse(w_clear)
    );

    assign w_full     = r_count == CW'(LAP_DEPTH);
    assign w_tick     = r_state == ST_RUN && r_presc == PW'(TICK_DIV - 1);
    assign w_inc      = bcd_time_inc(r_time, MIN_LIMIT);
    // Lap only acts when neither clear nor start claims the cycle.
    assign w_lap_wr   = w_lap && !w_clear && !w_start && r_state == ST_RUN && !w_full;
    assign w_lap_view = w_lap && !w_clear && !w_start && r_state != ST_RUN && r_count != '0;

    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_clear)
            w_state_next = ST_IDLE;
        else if (w_start)
            w_state_next = (r_state == ST_RUN) ? ST_PAUSE : ST_RUN;
    end

    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) begin
            r_presc <= '0;
            r_time  <= TIME_ZERO;
            r_wrap  <= 1'b0;
        end else if (w_clear) begin
            r_presc <= '0;
            r_time  <= TIME_ZERO;
            r_wrap  <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick)
                r_time <= w_inc.t;
            if (w_tick && w_inc.wrap)
                r_wrap <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) begin
            for (int i = 0; i < LAP_DEPTH; i++)
                r_lap[i] <= TIME_ZERO;
            r_count <= '0;
        end else if (w_clear)
            r_count <= '0;
        else if (w_lap_wr) begin
            r_lap[r_count[IW-1:0]] <= r_time;
            r_count                <= r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) begin
            r_view <= 1'b0;
            r_idx  <= '0;
        end else if (w_clear || w_start) begin
            r_view <= 1'b0;
            r_idx  <= '0;
        end else if (w_lap_view) begin
            if (!r_view) begin
                r_view <= 1'b1;
                r_idx  <= '0;
            end else if ({1'b0, r_idx} == r_count - 1'b1) begin
                r_view <= 1'b0;
                r_idx  <= '0;
            end else
                r_idx <= r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset)
            r_disp <= TIME_ZERO;
        else
            r_disp <= r_view ? r_lap[r_idx] : r_time;
    end

    assign data0    = r_disp.cc_l;
    assign data1    = r_disp.cc_h;
    assign data2    = r_disp.ss_l;
    assign data3    = r_disp.ss_h;
    assign data4    = r_disp.mm_l;
    assign data5    = r_disp.mm_h;
    assign led_run  = r_state == ST_RUN;
    assign led_view = r_view;
    assign led_full = w_full;
    assign led_wrap = r_wrap;

endmodule

// File: tb/tb_lap_stopwatch.sv
// tb_lap_stopwatch: directed table plus hand sequences against a centisecond reference model.
module tb_lap_stopwatch;

    localparam int TD = 2;
    localparam int DB = 4;
    localparam int LD = 4;
    localparam int ML = 1;
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_START = 3'd1;
    localparam logic [2:0] OP_LAP   = 3'd2;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    logic clk = 0;
    logic key_reset = 0;
    logic key_start_pause = 1;
    logic key_lap = 1;
    logic key_clear = 1;
    logic [3:0] data0, data1, data2, data3, data4, data5;
    logic led_run, led_view, led_full, led_wrap;
    logic [23:0] dig;
    logic [3:0] leds;

    int n_vec = 0;
    int n_bad = 0;
    int L = 0;
    int m_cs = 0;
    int m_presc = 0;
    int m_cnt = 0;
    bit m_run = 0;
    bit m_zero = 0;
    int cap [LD];

    typedef struct {
        logic [2:0] op;
        logic [3:0] leds;
        int         show;
    } vec_t;
    vec_t vecs [17];

    always #5 clk = ~clk;

    lap_stopwatch #(.TICK_DIV(TD), .DB_CYCLES(DB), .LAP_DEPTH(LD), .MIN_LIMIT(ML)) dut (
        .clk(clk), .key_reset(key_reset), .key_start_pause(key_start_pause),
        .key_lap(key_lap), .key_clear(key_clear),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3), .data4(data4), .data5(data5),
        .led_run(led_run), .led_view(led_view), .led_full(led_full), .led_wrap(led_wrap)
    );

    assign dig  = {data5, data4, data3, data2, data1, data0};
    assign leds = {led_run, led_view, led_full, led_wrap};

    always @(posedge clk) begin
        if (m_zero) begin
            m_cs    <= 0;
            m_presc <= 0;
        end else if (m_run) begin
            if (m_presc == TD - 1) begin
                m_presc <= 0;
                m_cs    <= (m_cs == (ML + 1) * 6000 - 1) ? 0 : m_cs + 1;
            end else
                m_presc <= m_presc + 1;
        end
    end

    function automatic logic [23:0] cs2d(input int cs);
        int mm = cs / 6000;
        int ss = (cs / 100) % 60;
        int cc = cs % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic press(input logic [2:0] op);
        key_start_pause = !op[0];
        key_lap         = !op[1];
        key_clear       = !op[2];
        repeat (L - 1) @(negedge clk);
        if (op == OP_LAP && m_run && m_cnt < LD) begin
            cap[m_cnt] = m_cs;
            m_cnt++;
        end
        @(negedge clk);
        if (op[2]) begin
            m_run  = 0;
            m_zero = 1;
            m_cnt  = 0;
        end else if (op[0])
            m_run = !m_run;
        repeat (3) @(negedge clk);
        key_start_pause = 1;
        key_lap         = 1;
        key_clear       = 1;
        m_zero          = 0;
        repeat (DB + 8) @(negedge clk);
    endtask

    initial begin
        int changes;
        int e;
        bit prev;
        vecs[0]  = '{OP_LAP,   4'b1000, -2};
        vecs[1]  = '{OP_LAP,   4'b1000, -2};
        vecs[2]  = '{OP_LAP,   4'b1000, -2};
        vecs[3]  = '{OP_LAP,   4'b1010, -2};
        vecs[4]  = '{OP_LAP,   4'b1010, -2};
        vecs[5]  = '{OP_START, 4'b0010, -1};
        vecs[6]  = '{OP_LAP,   4'b0110,  0};
        vecs[7]  = '{OP_LAP,   4'b0110,  1};
        vecs[8]  = '{OP_LAP,   4'b0110,  2};
        vecs[9]  = '{OP_LAP,   4'b0110,  3};
        vecs[10] = '{OP_LAP,   4'b0010, -1};
        vecs[11] = '{OP_LAP,   4'b0110,  0};
        vecs[12] = '{OP_START, 4'b1010, -2};
        vecs[13] = '{OP_START, 4'b0010, -1};
        vecs[14] = '{OP_NONE,  4'b0010, -1};
        vecs[15] = '{OP_CLEAR, 4'b0000, -1};
        vecs[16] = '{OP_LAP,   4'b0000, -1};

        repeat (3) @(negedge clk);
        chk("reset digits", dig, 0);
        chk("reset leds", leds, 0);
        key_reset = 1;
        repeat (3) @(negedge clk);

        key_start_pause = 0;
        for (int k = 1; k <= 100 && L == 0; k++) begin
            @(negedge clk);
            if (led_run) L = k;
        end
        if (L == 0) begin
            $display("FAIL first start: led_run %0b, required 1", led_run);
            $fatal(1);
        end
        m_run = 1;
        repeat (3) @(negedge clk);
        key_start_pause = 1;
        repeat (198) @(negedge clk);
        chk("200clk digits", dig, 24'h000100);
        chk("200clk run", led_run, 1);

        for (int i = 0; i < 17; i++) begin
            press(vecs[i].op);
            chk($sformatf("vec%0d leds", i), leds, vecs[i].leds);
            if (vecs[i].show == -1)
                chk($sformatf("vec%0d live", i), dig, cs2d(m_cs));
            else if (vecs[i].show >= 0)
                chk($sformatf("vec%0d lap%0d", i, vecs[i].show), dig, cs2d(cap[vecs[i].show]));
        end

        press(OP_START);
        press(OP_LAP);
        press(OP_START | OP_CLEAR);
        chk("clr+start run", led_run, 0);
        chk("clr+start digits", dig, 0);
        press(OP_LAP);
        chk("clr laps empty", led_view, 0);

        changes = 0;
        prev = led_run;
        for (int k = 0; k < 66; k++) begin
            key_start_pause = (k < 6) ? k[0] : (k < 36) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (led_run != prev) changes++;
            prev = led_run;
        end
        chk("bounce transitions", changes, 1);
        chk("bounce run", led_run, 1);
        press(OP_CLEAR);

        press(OP_START);
        for (int k = 0; k < 4000 && !(m_cs + (m_presc + L) / TD == 537 && (m_presc + L) % TD == 1); k++)
            @(negedge clk);
        press(OP_START);
        chk("pause 05:37", dig, 24'h000537);
        repeat (10 * TD) @(negedge clk);
        chk("pause hold", dig, 24'h000537);
        chk("pause hold run", led_run, 0);
        press(OP_START);
        e = DB + 11 + L;
        if (e % 2 == 0) begin
            @(negedge clk);
            e++;
        end
        press(OP_START);
        chk("resume phase", dig, cs2d(537 + (1 + e) / TD));
        chk("resume model", dig, cs2d(m_cs));

        press(OP_CLEAR);
        press(OP_START);
        for (int k = 0; k < 30000 && !(m_cs + (m_presc + L - 1) / TD == 11999 && (m_presc + L - 1) % TD == TD - 1); k++)
            @(negedge clk);
        key_lap = 0;
        repeat (L) @(negedge clk);
        chk("pre-wrap digits", dig, 24'h015999);
        @(negedge clk);
        chk("wrap digits", dig, 0);
        chk("wrap led", led_wrap, 1);
        chk("wrap run", led_run, 1);
        repeat (3) @(negedge clk);
        key_lap = 1;
        repeat (DB + 8) @(negedge clk);
        press(OP_START);
        press(OP_LAP);
        chk("wrap lap leds", leds, 4'b0101);
        chk("wrap lap value", dig, 24'h015999);

        press(OP_START);
        repeat (20) @(negedge clk);
        chk("pre-reset run", led_run, 1);
        @(posedge clk);
        #2 key_reset = 0;
        #1;
        chk("async reset digits", dig, 0);
        chk("async reset leds", leds, 0);
        @(negedge clk);
        key_reset = 1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
